// File: rtl/tmds_capture_packer.sv
//------------------------------------------------------------------------------
// tmds_capture_packer : triggered capture of raw TMDS symbols into 40-bit words
// Optional macro CAPTURE_VDE_ONLY_EN: only vde=1 samples are capture candidates.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tmds_capture_packer #(
   parameter int   CAPTURE_LEN = 1024,
   parameter logic VS_POL      = 1'b1
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        pll_lckd,
   input  logic [29:0] sdata,
   input  logic        vde,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        arm,
   input  logic        abort,
   input  logic        fifo_full,
   output logic        fifo_wr,
   output logic [39:0] fifo_din,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [15:0] count
);

   localparam logic [1:0]  c_IDLE    = 2'd0;
   localparam logic [1:0]  c_ARMED   = 2'd1;
   localparam logic [1:0]  c_CAPTURE = 2'd2;
   localparam logic [1:0]  c_DONE    = 2'd3;
   localparam logic [15:0] c_LEN     = CAPTURE_LEN[15:0];

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic        r_vs_prev;
   logic        r_fifo_wr;
   logic [39:0] r_fifo_din;
   logic        r_overflow;
   logic [15:0] r_count;

   logic w_trig;
   logic w_in_win;
   logic w_vde_ok;
   logic w_cand;
   logic w_wr;
   logic w_drop;
   logic w_last;
   logic w_arm_ok;

   assign w_trig   = (r_vs_prev != VS_POL) && (vsync == VS_POL);
   // The trigger-cycle sample is already part of the capture window.
   assign w_in_win = (r_state == c_CAPTURE) || ((r_state == c_ARMED) && w_trig);

`ifdef CAPTURE_VDE_ONLY_EN
   assign w_vde_ok = vde;
`else
   assign w_vde_ok = 1'b1;
`endif

   assign w_cand   = w_in_win && w_vde_ok && !abort && pll_lckd;
   assign w_wr     = w_cand && !fifo_full && (r_count < c_LEN);
   assign w_drop   = w_cand && fifo_full;
   assign w_last   = w_wr && (r_count == (c_LEN - 16'd1));
   assign w_arm_ok = arm && !abort && pll_lckd &&
                     ((r_state == c_IDLE) || (r_state == c_DONE));

   always_ff @(posedge pclk) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (abort || !pll_lckd) begin
         w_next = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE:    if (arm) w_next = c_ARMED;
            c_ARMED:   if (w_trig) w_next = w_last ? c_DONE : c_CAPTURE;
            c_CAPTURE: if (w_last) w_next = c_DONE;
            c_DONE:    if (arm) w_next = c_ARMED;
            default:   w_next = c_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (r_state == c_ARMED) || (r_state == c_CAPTURE);
      done = (r_state == c_DONE);
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         r_vs_prev  <= ~VS_POL;
         r_fifo_wr  <= 1'b0;
         r_fifo_din <= 40'd0;
         r_overflow <= 1'b0;
         r_count    <= 16'd0;
      end else begin
         r_vs_prev <= pll_lckd ? vsync : 1'b0;
         r_fifo_wr <= w_wr;
         if (w_wr) begin
            r_fifo_din <= {sdata, vde, hsync, vsync, r_count[6:0]};
         end
         if (w_arm_ok) begin
            r_count    <= 16'd0;
            r_overflow <= 1'b0;
         end else begin
            if (w_wr) r_count <= r_count + 16'd1;
            if (w_drop) r_overflow <= 1'b1;
         end
      end
   end

   assign fifo_wr  = r_fifo_wr;
   assign fifo_din = r_fifo_din;
   assign overflow = r_overflow;
   assign count    = r_count;

endmodule

`default_nettype wire
